// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants, state encoding and Rcon table
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } ksState_t;

    // Rcon bytes for rounds 1..10, round 1 in the most significant byte
    localparam logic [79:0] RCON_TAB = 80'h01_02_04_08_10_20_40_80_1b_36;

endpackage

// File: rtl/Rcon.sv
// rtl/Rcon.sv - round constant word for key-expansion rounds 1..NR
module Rcon
    import aes_pkg::*;
(
    input  logic [3:0]  round,
    output logic [0:31] rconWord
);

    logic [3:0] offset;

    // look up the round constant; indices outside 1..NR yield zero
    always_comb begin
        offset   = 4'(NR) - round;
        rconWord = '0;
        if (round >= 4'd1 && round <= 4'(NR))
            rconWord = {RCON_TAB[{offset, 3'b000} +: 8], 24'h000000};
    end

endmodule

// File: rtl/RotWord.sv
// rtl/RotWord.sv - cyclic one-byte left rotation of a key word
module RotWord (
    input  logic [0:31] wordIn,
    output logic [0:31] wordOut
);

    assign wordOut = {wordIn[8:31], wordIn[0:7]};

endmodule

// File: rtl/SubWord.sv
// rtl/SubWord.sv - AES S-box applied to each byte of a key word
module SubWord (
    input  logic [0:31] wordIn,
    output logic [0:31] wordOut
);

    // S-box row-major, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    assign wordOut = {sbox(wordIn[0:7]), sbox(wordIn[8:15]),
                      sbox(wordIn[16:23]), sbox(wordIn[24:31])};

endmodule

// File: rtl/ks_step.sv
// rtl/ks_step.sv - one forward or inverse AES-128 key-expansion step around a shared SubWord
module ks_step (
    input  logic         dir,
    input  logic [0:127] keyIn,
    input  logic [0:31]  rconWord,
    output logic [0:127] keyOut
);

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] p3, subIn, rotOut, subOut, t;

    assign w0 = keyIn[0:31];
    assign w1 = keyIn[32:63];
    assign w2 = keyIn[64:95];
    assign w3 = keyIn[96:127];

    // the inverse step must first recover the previous w3 before it can feed SubWord
    assign p3    = w3 ^ w2;
    assign subIn = dir ? p3 : w3;

    RotWord uRot (.wordIn(subIn),  .wordOut(rotOut));
    SubWord uSub (.wordIn(rotOut), .wordOut(subOut));

    assign t = w0 ^ subOut ^ rconWord;

    // forward chains the new words left to right; inverse undoes that chaining
    always_comb begin
        keyOut = '0;
        if (dir)
            keyOut = {t, w1 ^ w0, w2 ^ w1, p3};
        else
            keyOut = {t, t ^ w1, t ^ w1 ^ w2, t ^ w1 ^ w2 ^ w3};
    end

endmodule

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - iterative AES-128 inverse key scheduler (optional key cache: INV_KS_KEY_CACHE_EN)
module inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         done
);

    import aes_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    ksState_t     state, nextState;
    logic [0:127] keyReg, stepOut, cachedKey;
    logic [3:0]   cnt, rconIdx;
    logic [0:31]  rconWord;
    logic         stepDir, cacheHit, doneReg;

    // forward step at count c produces round c+1; inverse step from round r uses Rcon(r)
    assign rconIdx = (state == FWD) ? cnt + 4'd1 : cnt;
    assign stepDir = (state == REV);

    Rcon uRcon (.round(rconIdx), .rconWord(rconWord));

    ks_step uStep (
        .dir      (stepDir),
        .keyIn    (keyReg),
        .rconWord (rconWord),
        .keyOut   (stepOut)
    );

`ifdef INV_KS_KEY_CACHE_EN
    logic [0:127] cacheTag;
    logic         cacheValid;

    assign cacheHit = cacheValid && (key_in == cacheTag);

    // remember the latest cipher key and its round-10 key once the forward pass completes
    always_ff @(posedge clk) begin
        if (rst) begin
            cacheValid <= 1'b0;
            cacheTag   <= '0;
            cachedKey  <= '0;
        end else if (state == IDLE && start && !cacheHit) begin
            cacheTag   <= key_in;
            cacheValid <= 1'b0;
        end else if (state == FWD && cnt == LAST_ROUND - 4'd1) begin
            cachedKey  <= stepOut;
            cacheValid <= 1'b1;
        end
    end
`else
    assign cacheHit  = 1'b0;
    assign cachedKey = '0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // next-state decode
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = cacheHit ? REV : FWD;
            FWD:  if (cnt == LAST_ROUND - 4'd1) nextState = REV;
            REV:  if (rk_ready && cnt == 4'd0) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // key register, round counter and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            keyReg  <= '0;
            cnt     <= 4'd0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= (state == REV) && rk_ready && (cnt == 4'd0);
            case (state)
                IDLE: begin
                    if (start) begin
                        keyReg <= cacheHit ? cachedKey : key_in;
                        cnt    <= cacheHit ? LAST_ROUND : 4'd0;
                    end
                end
                FWD: begin
                    keyReg <= stepOut;
                    cnt    <= cnt + 4'd1;
                end
                REV: begin
                    if (rk_ready && cnt != 4'd0) begin
                        keyReg <= stepOut;
                        cnt    <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs; the working key stays hidden until the reverse walk begins
    always_comb begin
        busy     = (state != IDLE);
        rk_valid = (state == REV);
        rk       = (state == REV) ? keyReg : '0;
        rk_round = (state == REV) ? cnt : 4'd0;
        done     = doneReg;
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - randomized self-checking bench for inv_key_schedule
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst, start, rk_ready;
    logic [0:127] key_in;
    logic         busy, rk_valid, done;
    logic [0:127] rk;
    logic [3:0]   rk_round;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inv_key_schedule #(.NR(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk(rk), .rk_round(rk_round), .done(done)
    );

`ifdef INV_KS_KEY_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 11;
`endif

    localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [7:0]   sboxTab [0:255];
    logic [0:127] expRk   [0:10];
    logic [0:127] gotRk   [0:10];
    logic [3:0]   gotRound[0:10];
    int           gotCyc  [0:10];
    int           holdBad, zeroBad;
    bit           timedOut;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sboxTab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // textbook 44-word key expansion; round r key is words 4r..4r+3
    task automatic expand(input logic [0:127] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) expRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_key(input logic [0:127] k);
        key_in = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0; key_in = rand128();
    endtask

    // returns the cycle (start = cycle 0) of the first rk_valid, with an optional start pulse
    task automatic wait_valid(input int pulseCycle, output int lat);
        lat = 1; zeroBad = 0;
        while (rk_valid !== 1'b1 && lat < 40) begin
            if (rk !== 128'h0 || rk_round !== 4'd0 || busy !== 1'b1) zeroBad++;
            start = (lat == pulseCycle);
            if (start) key_in = rand128();
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    // consume 11 round keys; stops on the cycle where done is expected
    task automatic collect(input int readyPct, input int pulseIter, input int stallIter, input int stallLen);
        int n = 0;
        int it = 0;
        bit holding = 1'b0;
        logic [0:127] lastRk = '0;
        logic [3:0] lastRound = '0;
        holdBad = 0;
        for (int i = 0; i <= 10; i++) begin gotRk[i] = '0; gotRound[i] = '0; gotCyc[i] = -1; end
        while (n < 11 && it < 300) begin
            if (holding && (rk !== lastRk || rk_round !== lastRound)) holdBad++;
            holding = 1'b0;
            start = (it == pulseIter);
            if (start) key_in = rand128();
            if (rk_valid === 1'b1) begin
                rk_ready = ($urandom_range(99) < readyPct) && !(it >= stallIter && it < stallIter + stallLen);
                if (rk_ready) begin
                    gotRk[n] = rk; gotRound[n] = rk_round; gotCyc[n] = it; n++;
                end else begin
                    holding = 1'b1; lastRk = rk; lastRound = rk_round;
                end
            end else begin
                rk_ready = 1'b0;
            end
            @(negedge clk);
            it++;
        end
        start = 1'b0; rk_ready = 1'b0;
        timedOut = (n < 11);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = rand128();
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b expected 0", rk_valid); end
        checks++; if (rk !== 128'h0)     begin errors++; $display("FAIL reset_rk: got %h expected 0", rk); end
        checks++; if (rk_round !== 4'd0) begin errors++; $display("FAIL reset_rk_round: got %0d expected 0", rk_round); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_fips();
        int lat;
        do_reset();
        expand(FIPS_KEY);
        start_key(FIPS_KEY);
        wait_valid(-1, lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL fips_latency: got %0d expected 11", lat); end
        checks++; if (zeroBad != 0) begin errors++; $display("FAIL fips_fwd_outputs: %0d cycles with nonzero rk/round or busy low, expected 0", zeroBad); end
        collect(100, -1, -1, 0);
        checks++; if (timedOut) begin errors++; $display("FAIL fips_timeout: fewer than 11 handshakes, expected 11"); end
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (gotRk[n] !== expRk[10-n] || gotRound[n] !== 4'(10-n) || gotCyc[n] != n) begin
                errors++;
                $display("FAIL fips_round%0d: got rk=%h round=%0d at +%0d, expected rk=%h round=%0d at +%0d",
                         10-n, gotRk[n], gotRound[n], gotCyc[n], expRk[10-n], 10-n, n);
            end
        end
        checks++; if (gotRk[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL fips_kat_r10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", gotRk[0]); end
        checks++; if (gotRk[1] !== 128'hac7766f319fadc2128d12941575c006e) begin errors++; $display("FAIL fips_kat_r9: got %h expected ac7766f319fadc2128d12941575c006e", gotRk[1]); end
        checks++; if (gotRk[9] !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL fips_kat_r1: got %h expected a0fafe1788542cb123a339392a6c7605", gotRk[9]); end
        checks++; if (gotRk[10] !== FIPS_KEY) begin errors++; $display("FAIL fips_kat_r0: got %h expected %h", gotRk[10], FIPS_KEY); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fips_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fips_done_pulse: got done=%b one cycle later, expected 0", done); end
    endtask

    task automatic test_zero_key();
        int lat;
        do_reset();
        expand(128'h0);
        start_key(128'h0);
        wait_valid(-1, lat);
        collect(100, -1, -1, 0);
        checks++; if (lat != 11 || timedOut) begin errors++; $display("FAIL zero_latency: got lat=%0d timeout=%0b expected 11/0", lat, timedOut); end
        checks++; if (gotRk[9] !== 128'h62636363626363636263636362636363) begin errors++; $display("FAIL zero_r1: got %h expected 62636363 x4", gotRk[9]); end
        checks++; if (gotRk[10] !== 128'h0 || gotRound[10] !== 4'd0) begin errors++; $display("FAIL zero_r0: got %h round %0d expected 0 round 0", gotRk[10], gotRound[10]); end
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (gotRk[n] !== expRk[10-n]) begin errors++; $display("FAIL zero_round%0d: got %h expected %h", 10-n, gotRk[n], expRk[10-n]); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_reset();
        expand(FIPS_KEY);
        start_key(FIPS_KEY);
        wait_valid(-1, lat);
        collect(100, -1, 1, 5);
        checks++; if (timedOut) begin errors++; $display("FAIL bp_timeout: fewer than 11 handshakes, expected 11"); end
        checks++; if (holdBad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable stalled cycles, expected 0", holdBad); end
        checks++; if (gotCyc[1] != 6 || gotCyc[10] != 15) begin errors++; $display("FAIL bp_timing: got r9 at +%0d r0 at +%0d, expected +6 and +15", gotCyc[1], gotCyc[10]); end
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (gotRk[n] !== expRk[10-n] || gotRound[n] !== 4'(10-n)) begin
                errors++; $display("FAIL bp_round%0d: got %h round %0d expected %h", 10-n, gotRk[n], gotRound[n], expRk[10-n]);
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done); end
    endtask

    task automatic test_start_ignored();
        int lat;
        do_reset();
        expand(FIPS_KEY);
        start_key(FIPS_KEY);
        wait_valid(4, lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL ign_latency: got %0d expected 11", lat); end
        collect(100, 5, -1, 0);
        checks++; if (timedOut) begin errors++; $display("FAIL ign_timeout: fewer than 11 handshakes, expected 11"); end
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (gotRk[n] !== expRk[10-n] || gotRound[n] !== 4'(10-n) || gotCyc[n] != n) begin
                errors++; $display("FAIL ign_round%0d: got %h round %0d at +%0d expected %h at +%0d", 10-n, gotRk[n], gotRound[n], gotCyc[n], expRk[10-n], n);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        int lat;
        logic [0:127] k;
        for (int t = 0; t < 5; t++) begin
            k = rand128();
            expand(k);
            start_key(k);
            wait_valid(-1, lat);
            checks++; if (lat != 11) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 11", t, lat); end
            collect(55, -1, -1, 0);
            checks++; if (timedOut || holdBad != 0) begin errors++; $display("FAIL rnd%0d_flow: timeout=%0b holdBad=%0d expected 0/0", t, timedOut, holdBad); end
            for (int n = 0; n <= 10; n++) begin
                checks++;
                if (gotRk[n] !== expRk[10-n] || gotRound[n] !== 4'(10-n)) begin
                    errors++; $display("FAIL rnd%0d_round%0d: got %h round %0d expected %h", t, 10-n, gotRk[n], gotRound[n], expRk[10-n]);
                end
            end
            checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_done: got done=%b busy=%b expected 1/0", t, done, busy); end
        end
    endtask

    task automatic test_reset_mid_rev();
        int lat;
        int guard = 0;
        logic [0:127] k;
        do_reset();
        k = rand128();
        expand(k);
        start_key(k);
        wait_valid(-1, lat);
        rk_ready = 1'b1;
        while (rk_round !== 4'd5 && guard < 20) begin @(negedge clk); guard++; end
        checks++; if (guard >= 20) begin errors++; $display("FAIL rstrev_reach5: round 5 not seen, got round %0d", rk_round); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rk_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || rk !== 128'h0 || rk_round !== 4'd0 || done !== 1'b0) begin
            errors++; $display("FAIL rstrev_outputs: got busy=%b valid=%b rk=%h round=%0d done=%b expected all 0", busy, rk_valid, rk, rk_round, done);
        end
        start_key(k);
        wait_valid(-1, lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL rstrev_latency: got %0d expected 11", lat); end
        collect(100, -1, -1, 0);
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (gotRk[n] !== expRk[10-n]) begin errors++; $display("FAIL rstrev_round%0d: got %h expected %h", 10-n, gotRk[n], expRk[10-n]); end
        end
    endtask

    task automatic test_cache();
        int lat;
        int expLat [0:4];
        logic [0:127] keys [0:4];
        logic [0:127] other;
        other = rand128();
        keys = '{FIPS_KEY, FIPS_KEY, other, other, other};
        expLat = '{11, HIT_LAT, 11, HIT_LAT, 11};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            if (t == 4) do_reset();
            expand(keys[t]);
            start_key(keys[t]);
            wait_valid(-1, lat);
            checks++; if (lat != expLat[t]) begin errors++; $display("FAIL cache%0d_latency: got %0d expected %0d", t, lat, expLat[t]); end
            collect(100, -1, -1, 0);
            for (int n = 0; n <= 10; n++) begin
                checks++;
                if (gotRk[n] !== expRk[10-n] || gotRound[n] !== 4'(10-n)) begin
                    errors++; $display("FAIL cache%0d_round%0d: got %h round %0d expected %h", t, 10-n, gotRk[n], gotRound[n], expRk[10-n]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        build_sbox();
        @(negedge clk);
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_start_ignored();
        test_back_to_back_random();
        test_reset_mid_rev();
        test_cache();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

- Iterative AES-128 inverse key scheduler for the decryption datapath.
- Takes the 128-bit cipher key and runs a 10-cycle forward expansion to obtain the round-10 key.
- Then streams round keys 10 down to 0, one per valid/ready handshake, each derived on the fly from the previous one with the inverse key-expansion step.
- Sits between the key register and the inverse-cipher round engine, which consumes round keys in reverse order.

## Interface
Parameters:
- NR, 10, number of AES rounds (fixed for AES-128; other values unsupported)

Ports (bit vectors big-endian, MSB = bit 0, as in the key-expansion blocks):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a schedule; sampled only in IDLE
- key_in  in  [0:127]  cipher key, sampled in the cycle `start` is accepted
- busy  out  1  high in every state except IDLE
- rk_valid  out  1  `rk` and `rk_round` hold a valid round key
- rk_ready  in  1  consumer accepts the round key when `rk_valid` and `rk_ready` are both high
- rk  out  [0:127]  round key
- rk_round  out  [3:0]  round index of `rk` (10 down to 0)
- done  out  1  one-cycle pulse after round 0 is accepted

## Operation
- States: IDLE, FWD, REV.
- **IDLE:**
  - If `start`=1: load `key_in` into the state register and set cnt=0.
  - Next state is FWD, or REV on a cache hit (see Configuration).
- **FWD:**
  - Each cycle performs one forward expansion step with Rcon(cnt+1), then cnt++.
  - After the step that produces round 10, go to REV with `rk_round`=10.
- **Forward step** (words w0..w3):
  - n0 = w0 ^ SubWord(RotWord(w3)) ^ Rcon(i)
  - n1 = w1 ^ n0
  - n2 = w2 ^ n1
  - n3 = w3 ^ n2
- **REV:**
  - `rk_valid`=1 throughout.
  - On handshake with `rk_round`>0: replace `rk` with the inverse step using Rcon(`rk_round`), then `rk_round`--.
  - On handshake with `rk_round`=0: go to IDLE and pulse `done`.
- **Inverse step:**
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(i)
- **Backpressure:** while `rk_valid` && !`rk_ready`, `rk` and `rk_round` hold stable.
- `start` during FWD or REV is ignored; there is no abort except `rst`.
- The state register is internal during FWD. `rk` outputs 0 until REV.

## Timing
- Reset values:
  - `busy`=0, `rk_valid`=0, `rk`=0, `rk_round`=0, `done`=0
  - state = IDLE; cache invalid
- `rst` has priority over everything. Reset mid-FWD or mid-REV returns all outputs to reset values on the next cycle, with no `done`.
- Latency: `start` accepted in cycle 0 means FWD in cycles 1–10 and first `rk_valid` in cycle 11 (round 10). On a cache hit, first `rk_valid` is in cycle 1.
- With `rk_ready` tied high, rounds 10..0 appear in 11 consecutive cycles.
- `done` is high in the cycle after the round-0 handshake, together with `busy`=0.
- A new `start` is accepted in that same `done` cycle.
- One SubWord in the critical path per cycle. The forward and inverse steps share a single SubWord instance through a mux.

## Configuration
- Macro: INV_KS_KEY_CACHE_EN.
- **Defined:**
  - A 128-bit tag register holds the last fully expanded cipher key.
  - A 128-bit register holds its round-10 key, plus a valid bit, set on entry to REV.
  - `start` with `key_in` equal to the tag and valid=1 skips FWD: `rk` loads the cached key and the block enters REV with `rk_round`=10.
  - `rst` clears valid.
- **Undefined:** no cache registers; every `start` takes the full FWD pass.

## Structure
- Shared package aes_pkg holds:
  - NR=10
  - the state encoding (IDLE/FWD/REV)
  - the Rcon byte table for rounds 1..10
- Existing RotWord, SubWord and Rcon modules are instantiated, not duplicated.
- One natural sub-module: ks_step. It is combinational, takes a `dir` input, and computes the forward or inverse step around the shared SubWord.

## Test plan
1. FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, `rk_ready`=1, `start` in cycle 0:
   - cycle 11: `rk_round`=10, `rk`=d014f9a8_c9ee2589_e13f0cc8_b6630ca6
   - cycle 12: round 9 = ac7766f3_19fadc21_28d12941_575c006e
   - cycle 20: round 1 = a0fafe17_88542cb1_23a33939_2a6c7605
   - cycle 21: round 0 = `key_in`
   - cycle 22: `done`.
2. All-zero key: round 1 = 62636363 ×4; round 0 = 0.
3. Backpressure: `rk_ready`=0 for 5 cycles while round 9 is presented. `rk` and `rk_round` stay stable, and the sequence resumes unchanged.
4. `start` pulsed with a different key during FWD and during REV: ignored, output sequence identical to test 1.
5. `rst` asserted during REV at round 5: next cycle all outputs are 0 and `busy`=0. A following `start` yields round 10 at cycle 11.
6. With INV_KS_KEY_CACHE_EN:
   - repeat test 1 key: round 10 appears in cycle 1
   - different key: 11 cycles
   - after `rst`, the same key takes 11 cycles.
